// File: rtl/mq_interval_seq.sv
// MQ coder interval update and renormalisation sequencer: computes the new A,
// picks the next probability index and emits CT-bounded shift beats downstream.
module mq_interval_seq #(
    parameter int         AW      = 16,
    parameter int         SW      = $clog2(AW),
    parameter logic [3:0] CT_INIT = 4'd12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] qe,
    input  logic          mps_coding,
    input  logic [5:0]    nmps,
    input  logic [5:0]    nlps,
    input  logic [5:0]    qe_index,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          stuff,
    output logic          c_add,
    output logic [SW-1:0] shift_amt,
    output logic          byte_out,
    output logic          last,
    output logic [5:0]    index_out,
    output logic [AW-1:0] a_value,
    output logic [3:0]    ct
);

    localparam logic [AW-1:0] A_RST = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_BEAT} state_t;

    state_t        state_q;
    logic [AW-1:0] a_q;
    logic [3:0]    ct_q;
    logic [SW-1:0] rem_q;
    logic          c_add_q;
    logic [SW-1:0] shift_q;
    logic          byte_q;
    logic          last_q;
    logic [5:0]    idx_q;

    logic [AW-1:0] a_sub, a_cal, a_in, a_d;
    logic          sel, no_renorm, lz_found;
    logic [SW-1:0] lz_cnt, sym_rem, rem_in, seg, rem_d;
    logic [5:0]    sym_idx;
    logic [3:0]    ct_eff, ct_d;
    logic          accept_sym, accept_beat, load_beat;

    assign out_valid   = (state_q == S_BEAT);
    assign in_ready    = ~flush & ((state_q == S_IDLE) | (out_valid & last_q & out_ready));
    assign accept_sym  = in_valid & in_ready;
    assign accept_beat = out_valid & out_ready;
    assign load_beat   = accept_sym | (accept_beat & ~last_q);

    // Symbol-level interval arithmetic with conditional exchange.
    always_comb begin
        a_sub     = a_q - qe;
        sel       = ~((a_sub >= qe) ^ mps_coding);
        a_cal     = sel ? a_sub : qe;
        no_renorm = mps_coding & a_sub[AW-1];
        lz_cnt    = SW'(AW-1);
        lz_found  = 1'b0;
        for (int i = AW-1; i >= 0; i--) begin
            if (!lz_found && a_cal[i]) begin
                lz_cnt   = SW'(AW-1-i);
                lz_found = 1'b1;
            end
        end
        sym_rem = no_renorm ? '0 : lz_cnt;
        sym_idx = no_renorm ? qe_index : (mps_coding ? nmps : nlps);
    end

    // One beat: shift by as much of the remaining amount as CT allows.
    // CT reload from a byte_out beat being accepted right now is folded in here.
    always_comb begin
        ct_eff = (accept_beat & byte_q) ? (stuff ? 4'd7 : 4'd8) : ct_q;
        a_in   = accept_sym ? a_cal : a_q;
        rem_in = accept_sym ? sym_rem : rem_q;
        seg    = (rem_in < SW'(ct_eff)) ? rem_in : SW'(ct_eff);
        a_d    = a_in << seg;
        ct_d   = ct_eff - seg[3:0];
        rem_d  = rem_in - seg;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= S_IDLE;
            a_q     <= A_RST;
            ct_q    <= CT_INIT;
            rem_q   <= '0;
            c_add_q <= 1'b0;
            shift_q <= '0;
            byte_q  <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else if (load_beat) begin
            state_q <= S_BEAT;
            a_q     <= a_d;
            ct_q    <= ct_d;
            rem_q   <= rem_d;
            c_add_q <= accept_sym & sel;
            shift_q <= seg;
            byte_q  <= (ct_d == 4'd0);
            last_q  <= (rem_d == '0);
            if (accept_sym) begin
                idx_q <= sym_idx;
            end
        end else if (accept_beat) begin
            state_q <= S_IDLE;
            ct_q    <= ct_eff;
        end
    end

    assign c_add     = c_add_q;
    assign shift_amt = shift_q;
    assign byte_out  = byte_q;
    assign last      = last_q;
    assign index_out = idx_q;
    assign a_value   = a_q;
    assign ct        = ct_q;

endmodule

// File: tb/tb_mq_interval_seq.sv
// Directed bench for mq_interval_seq: table of single-beat symbols plus
// hand-written segmentation, stuffing, throughput and backpressure/flush cases.
module tb_mq_interval_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, mps_coding, out_valid, out_ready, stuff;
    logic [15:0] qe, a_value;
    logic [5:0]  nmps, nlps, qe_index, index_out;
    logic        c_add, byte_out, last;
    logic [3:0]  shift_amt, ct;

    int total = 0;
    int bad   = 0;

    mq_interval_seq dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .qe(qe), .mps_coding(mps_coding), .nmps(nmps), .nlps(nlps), .qe_index(qe_index),
        .out_valid(out_valid), .out_ready(out_ready), .stuff(stuff),
        .c_add(c_add), .shift_amt(shift_amt), .byte_out(byte_out), .last(last),
        .index_out(index_out), .a_value(a_value), .ct(ct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        mps;
        logic [15:0] qe;
        logic [5:0]  nmps;
        logic [5:0]  nlps;
        logic [5:0]  qidx;
        logic        cadd;
        logic [3:0]  sh;
        logic [15:0] a;
        logic [3:0]  ct;
        logic [5:0]  idx;
    } vec_t;

    vec_t v[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic ca, input logic [3:0] sh,
                            input logic bo, input logic ls, input logic [5:0] idx,
                            input logic [15:0] a, input logic [3:0] c);
        chk({name, ".out_valid"}, 32'(out_valid), 32'(1'b1));
        chk({name, ".c_add"},     32'(c_add),     32'(ca));
        chk({name, ".shift_amt"}, 32'(shift_amt), 32'(sh));
        chk({name, ".byte_out"},  32'(byte_out),  32'(bo));
        chk({name, ".last"},      32'(last),      32'(ls));
        if (ls) chk({name, ".index_out"}, 32'(index_out), 32'(idx));
        chk({name, ".a_value"},   32'(a_value),   32'(a));
        chk({name, ".ct"},        32'(ct),        32'(c));
        $display("beat %s: c_add=%0d shift=%0d byte_out=%0d last=%0d idx=%0d a=%h ct=%0d",
                 name, c_add, shift_amt, byte_out, last, index_out, a_value, ct);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic send(input logic m, input logic [15:0] q, input logic [5:0] nm,
                        input logic [5:0] nl, input logic [5:0] qi);
        @(negedge clk);
        mps_coding = m; qe = q; nmps = nm; nlps = nl; qe_index = qi;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic accept(input logic st);
        out_ready = 1'b1;
        stuff = st;
        @(posedge clk);
        #1 out_ready = 1'b0;
        stuff = 1'b0;
    endtask

    task automatic seg_case(input string name, input logic st, input logic [3:0] ct2);
        do_flush();
        send(1'b0, 16'h0001, 6'd19, 6'd20, 6'd21);
        @(negedge clk);
        chk_beat({name, ".b1"}, 1'b0, 4'd12, 1'b1, 1'b0, 6'd0, 16'h1000, 4'd0);
        out_ready = 1'b1; in_valid = 1'b1;
        #1 chk({name, ".in_ready_mid"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        accept(st);
        @(negedge clk);
        chk_beat({name, ".b2"}, 1'b0, 4'd3, 1'b0, 1'b1, 6'd20, 16'h8000, ct2);
        accept(1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stuff = 1'b0;
        mps_coding = 1'b0; qe = 16'h0001; nmps = '0; nlps = '0; qe_index = '0;

        //        fl    mps   qe        nmps   nlps   qidx   cadd  sh    a          ct     idx
        v[0] = '{1'b0, 1'b1, 16'h5601, 6'd1,  6'd2,  6'd3,  1'b0, 4'd1, 16'hAC02, 4'd11, 6'd1};
        v[1] = '{1'b0, 1'b1, 16'h0001, 6'd4,  6'd5,  6'd6,  1'b1, 4'd0, 16'hAC01, 4'd11, 6'd6};
        v[2] = '{1'b0, 1'b0, 16'h5601, 6'd7,  6'd9,  6'd8,  1'b1, 4'd1, 16'hAC00, 4'd10, 6'd9};
        v[3] = '{1'b0, 1'b1, 16'h5601, 6'd10, 6'd14, 6'd15, 1'b0, 4'd1, 16'hAC02, 4'd9,  6'd10};
        v[4] = '{1'b0, 1'b0, 16'h2000, 6'd16, 6'd11, 6'd17, 1'b0, 4'd2, 16'h8000, 4'd7,  6'd11};
        v[5] = '{1'b0, 1'b1, 16'h1000, 6'd12, 6'd18, 6'd22, 1'b1, 4'd1, 16'hE000, 4'd6,  6'd12};
        v[6] = '{1'b1, 1'b0, 16'h5601, 6'd23, 6'd13, 6'd24, 1'b1, 4'd2, 16'hA7FC, 4'd10, 6'd13};

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.a_value",   32'(a_value),   32'h8000);
        chk("reset.ct",        32'(ct),        32'd12);
        chk("reset.c_add",     32'(c_add),     32'd0);
        chk("reset.shift_amt", 32'(shift_amt), 32'd0);
        chk("reset.index_out", 32'(index_out), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (v[i].fl) do_flush();
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            send(v[i].mps, v[i].qe, v[i].nmps, v[i].nlps, v[i].qidx);
            @(negedge clk);
            chk_beat($sformatf("vec%0d", i), v[i].cadd, v[i].sh, 1'b0, 1'b1, v[i].idx, v[i].a, v[i].ct);
            accept(1'b0);
        end

        seg_case("seg", 1'b0, 4'd5);
        seg_case("stuff", 1'b1, 4'd4);

        // Back-to-back single-beat symbols: one per cycle with out_ready held high.
        do_flush();
        send(1'b1, 16'h5601, 6'd1, 6'd2, 6'd3);
        mps_coding = 1'b1; qe = 16'h0001; nmps = 6'd4; nlps = 6'd5; qe_index = 6'd6;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk_beat("tput.b1", 1'b0, 4'd1, 1'b0, 1'b1, 6'd1, 16'hAC02, 4'd11);
        chk("tput.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk_beat("tput.b2", 1'b1, 4'd0, 1'b0, 1'b1, 6'd6, 16'hAC01, 4'd11);
        accept(1'b0);

        // Backpressure holds the first beat, then flush drops it.
        do_flush();
        send(1'b0, 16'h0001, 6'd19, 6'd20, 6'd21);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_beat($sformatf("hold%0d", k), 1'b0, 4'd12, 1'b1, 1'b0, 6'd0, 16'h1000, 4'd0);
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        #1 chk("flush.in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.a_value",   32'(a_value),   32'h8000);
        chk("flush.ct",        32'(ct),        32'd12);
        chk("flush.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        chk("flush.no_accept", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
